// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, mailbox register map and FSM state type.
package ahb_pkg;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_THRESH = 2'd3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_TX_FLUSH  = 2;
    localparam int CTRL_RX_FLUSH  = 3;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} ahb_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; DEPTH must be a power of two so pointers wrap for free.
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [DATA_W-1:0]      wdata_i,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    // Flush wins over everything, including a push arriving in the same cycle.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/ahb_stream_mailbox.sv
// AHB-Lite mailbox: DATA writes feed an outbound stream FIFO, DATA reads drain an inbound one.
module ahb_stream_mailbox
    import ahb_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic [DATA_W-1:0] hrdata,
    output logic              hreadyout,
    output logic [1:0]        hresp,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    ahb_state_e        state_q, state_d;
    logic [1:0]        addr_q, addr_d;
    logic              write_q, write_d;
    logic [1:0]        ctrl_q;
    logic [15:0]       thresh_q;
    logic              irq_q, irq_d;

    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]     tx_count, rx_count;
    logic [DATA_W-1:0] rx_head;
    logic [CW:0]       tx_cnt_eff, rx_cnt_eff;
    logic              addr_valid, err_req, dp_wr, dp_rd;
    logic              tx_push, tx_pop, rx_push, rx_pop, ctrl_wr, tx_flush, rx_flush;
    logic [DATA_W-1:0] status;
    logic              unused_ok;

    assign unused_ok  = ^{haddr[31:4], haddr[1:0]};
    assign addr_valid = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));

    assign dp_wr    = (state_q == S_DATA) & write_q;
    assign dp_rd    = (state_q == S_DATA) & ~write_q;
    assign tx_push  = dp_wr & (addr_q == REG_DATA);
    assign rx_pop   = dp_rd & (addr_q == REG_DATA);
    assign ctrl_wr  = dp_wr & (addr_q == REG_CTRL);
    assign tx_flush = ctrl_wr & hwdata[CTRL_TX_FLUSH];
    assign rx_flush = ctrl_wr & hwdata[CTRL_RX_FLUSH];
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & rx_ready;

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx (
        .clk_i(hclk), .rst_i(hreset), .push_i(tx_push), .pop_i(tx_pop), .flush_i(tx_flush),
        .wdata_i(hwdata), .rdata_o(tx_data), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx (
        .clk_i(hclk), .rst_i(hreset), .push_i(rx_push), .pop_i(rx_pop), .flush_i(rx_flush),
        .wdata_i(rx_data), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
    );

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    // Occupancy as it will stand after this edge; a TX pop is deliberately not credited.
    assign tx_cnt_eff = tx_flush ? '0 : {1'b0, tx_count} + (CW+1)'(tx_push);
    assign rx_cnt_eff = rx_flush ? '0 : {1'b0, rx_count} + (CW+1)'(rx_push) - (CW+1)'(rx_pop);

    assign err_req = (hsize != HSIZE_WORD)
                   | ((haddr[3:2] == REG_DATA) & hwrite & (tx_cnt_eff >= (CW+1)'(DEPTH)))
                   | ((haddr[3:2] == REG_DATA) & ~hwrite & (rx_cnt_eff == '0))
                   | ((haddr[3:2] == REG_STATUS) & hwrite);

    always_comb begin
        state_d = S_IDLE;
        addr_d  = addr_q;
        write_d = write_q;
        case (state_q)
            S_ERR1: state_d = S_ERR2;
            default: begin
                if (addr_valid) begin
                    if (err_req) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_DATA;
                        addr_d  = haddr[3:2];
                        write_d = hwrite;
                    end
                end
            end
        endcase
    end

    always_comb begin
        status                            = '0;
        status[ST_TX_FULL]                = tx_full;
        status[ST_TX_EMPTY]               = tx_empty;
        status[ST_RX_FULL]                = rx_full;
        status[ST_RX_EMPTY]               = rx_empty;
        status[ST_TX_CNT_LSB +: 8]        = 8'(tx_count);
        status[ST_RX_CNT_LSB +: 8]        = 8'(rx_count);
    end

    always_comb begin
        hrdata = '0;
        if (dp_rd) begin
            case (addr_q)
                REG_DATA:   hrdata = rx_head;
                REG_STATUS: hrdata = status;
                REG_CTRL:   hrdata = {{(DATA_W-2){1'b0}}, ctrl_q};
                default:    hrdata = {{(DATA_W-16){1'b0}}, thresh_q};
            endcase
        end
    end

    assign irq_d = (ctrl_q[CTRL_RX_IRQ_EN] & (thresh_q[7:0] != 8'd0) & (8'(rx_count) >= thresh_q[7:0]))
                 | (ctrl_q[CTRL_TX_IRQ_EN] & (8'(tx_count) <= thresh_q[15:8]));

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            ctrl_q   <= '0;
            thresh_q <= 16'h0001;
            irq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            irq_q   <= irq_d;
            if (ctrl_wr) ctrl_q <= hwdata[1:0];
            if (dp_wr && addr_q == REG_THRESH) thresh_q <= hwdata[15:0];
        end
    end

    assign hreadyout = (state_q != S_ERR1);
    assign hresp     = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign irq       = irq_q;
endmodule
